// File: rtl/sprite_anim_sequencer.sv
// Sprite ROM address generator with frame-tick-driven animation and optional horizontal mirror.
// Address, hit and hit_q are registered; the displayed frame only changes on frame_start.
module sprite_anim_sequencer #(
  parameter int unsigned SPR_W       = 80,
  parameter int unsigned SPR_H       = 100,
  parameter int unsigned NUM_FRAMES  = 6,
  parameter int unsigned FRAME_TICKS = 6,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic              frame_start,
  input  logic              anim_start,
  input  logic              anim_stop,
  input  logic              anim_loop,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_hit,
  output logic              hit_q,
  output logic [2:0]        disp_frame,
  output logic              anim_busy
);

  localparam logic [7:0] LastTick  = 8'(FRAME_TICKS - 1);
  localparam logic [2:0] LastFrame = 3'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [2:0]  next_frame_q, next_frame_d;

  logic [10:0]       dx, dy, col;
  logic              hit;
  logic [ADDR_W-1:0] addr_d;

  // State register
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      next_frame_q <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      next_frame_q <= next_frame_d;
    end
  end

  // Next-state logic; start beats stop, and either one swallows a coincident tick
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    next_frame_d = next_frame_q;
    if (anim_start) begin
      state_d      = StPlay;
      tick_d       = '0;
      next_frame_d = '0;
    end else if (anim_stop) begin
      state_d      = StIdle;
      tick_d       = '0;
      next_frame_d = '0;
    end else if (state_q == StPlay && frame_start) begin
      if (tick_q == LastTick) begin
        tick_d = '0;
        if (next_frame_q < LastFrame) begin
          next_frame_d = next_frame_q + 3'd1;
        end else if (anim_loop) begin
          next_frame_d = '0;
        end else begin
          state_d = StHold;
        end
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    anim_busy = (state_q == StPlay);
  end

  // Hit test in 11 bits so the subtraction cannot wrap at screen edges
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, spr_x};
    dy  = {1'b0, draw_y} - {1'b0, spr_y};
    hit = (draw_x >= spr_x) && (dx < 11'(SPR_W)) && (draw_y >= spr_y) && (dy < 11'(SPR_H));
    col = flip_h ? (11'(SPR_W - 1) - dx) : dx;
    if (hit) begin
      addr_d = ADDR_W'(disp_frame) * ADDR_W'(SPR_W * SPR_H)
             + ADDR_W'(dy) * ADDR_W'(SPR_W)
             + ADDR_W'(col);
    end else begin
      addr_d = '0;
    end
  end

  // Pixel pipeline and tear-free frame latch
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      sprite_hit  <= 1'b0;
      hit_q       <= 1'b0;
      disp_frame  <= '0;
    end else begin
      rom_address <= addr_d;
      sprite_hit  <= hit;
      hit_q       <= sprite_hit;
      if (frame_start) begin
        disp_frame <= next_frame_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_sprite_anim_sequencer;

  localparam int SPR_W = 80;
  localparam int SPR_H = 100;
  localparam int NF    = 6;
  localparam int FT    = 6;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x, draw_y, spr_x, spr_y;
  logic        frame_start, anim_start, anim_stop, anim_loop, flip_h;
  logic [15:0] rom_address;
  logic        sprite_hit, hit_q, anim_busy;
  logic [2:0]  disp_frame;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  sprite_anim_sequencer dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .frame_start (frame_start),
    .anim_start  (anim_start),
    .anim_stop   (anim_stop),
    .anim_loop   (anim_loop),
    .flip_h      (flip_h),
    .rom_address (rom_address),
    .sprite_hit  (sprite_hit),
    .hit_q       (hit_q),
    .disp_frame  (disp_frame),
    .anim_busy   (anim_busy)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: animation as frame index + pulse count, address from plain arithmetic
  logic [15:0] e_addr;
  bit          e_hit, e_hitq;
  int          m_disp, m_frame, m_tick;
  bit          m_play;

  always @(posedge vga_clk or posedge reset) begin : model
    int dx, dy;
    if (reset) begin
      e_addr  <= '0;
      e_hit   <= 1'b0;
      e_hitq  <= 1'b0;
      m_disp  <= 0;
      m_frame <= 0;
      m_tick  <= 0;
      m_play  <= 1'b0;
    end else begin
      dx = int'(draw_x) - int'(spr_x);
      dy = int'(draw_y) - int'(spr_y);
      e_hitq <= e_hit;
      if (dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
        e_hit  <= 1'b1;
        e_addr <= 16'(m_disp * SPR_W * SPR_H + dy * SPR_W + (flip_h ? SPR_W - 1 - dx : dx));
      end else begin
        e_hit  <= 1'b0;
        e_addr <= '0;
      end
      if (frame_start) m_disp <= m_frame;
      if (anim_start) begin
        m_play <= 1'b1; m_frame <= 0; m_tick <= 0;
      end else if (anim_stop) begin
        m_play <= 1'b0; m_frame <= 0; m_tick <= 0;
      end else if (m_play && frame_start) begin
        if (m_tick + 1 == FT) begin
          m_tick <= 0;
          if (m_frame + 1 < NF) m_frame <= m_frame + 1;
          else if (anim_loop)   m_frame <= 0;
          else                  m_play  <= 1'b0;  // holding: frame stays at the last one
        end else begin
          m_tick <= m_tick + 1;
        end
      end
    end
  end

  always @(negedge vga_clk) begin
    if (cmp_en) begin
      check("cyc_addr", 32'(rom_address), 32'(e_addr));
      check("cyc_hit", 32'(sprite_hit), 32'(e_hit));
      check("cyc_hit_q", 32'(hit_q), 32'(e_hitq));
      check("cyc_disp", 32'(disp_frame), 32'(m_disp));
      check("cyc_busy", 32'(anim_busy), 32'(m_play));
    end
  end

  task automatic apply();
    @(posedge vga_clk);
    #2;
    frame_start = 1'b0;
    anim_start  = 1'b0;
    anim_stop   = 1'b0;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    apply();
  endtask

  initial begin
    reset = 1'b1;
    draw_x = '0; draw_y = '0; spr_x = '0; spr_y = '0;
    frame_start = 0; anim_start = 0; anim_stop = 0; anim_loop = 0; flip_h = 0;
    repeat (2) apply();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Address and mirror
    spr_x = 100; spr_y = 50; draw_x = 103; draw_y = 52;
    apply();
    check("addr_plain", 32'(rom_address), 163);
    check("hit_plain", 32'(sprite_hit), 1);
    flip_h = 1;
    apply();
    check("addr_mirror", 32'(rom_address), 236);
    check("hit_q_follow", 32'(hit_q), 1);

    // Screen-edge boundaries
    flip_h = 0; spr_x = 1000; draw_x = 1020; draw_y = 60;
    apply();
    check("edge_hit", 32'(sprite_hit), 1);
    check("edge_addr", 32'(rom_address), 820);
    spr_x = 100; draw_x = 99;
    apply();
    check("left_miss", 32'(sprite_hit), 0);
    check("left_addr", 32'(rom_address), 0);
    check("left_hit_q", 32'(hit_q), 1);
    draw_x = 180;
    apply();
    check("right_miss", 32'(sprite_hit), 0);
    check("right_addr", 32'(rom_address), 0);
    check("right_hit_q", 32'(hit_q), 0);

    // One-shot animation into hold
    anim_loop = 0; anim_start = 1;
    apply();
    check("play_busy", 32'(anim_busy), 1);
    for (int k = 1; k <= 36; k++) begin
      pulse();
      check("oneshot_disp", 32'(disp_frame), 32'((k - 1) / 6));
      if (k == 20) begin
        spr_x = 200; spr_y = 300; draw_x = 200; draw_y = 300;
        apply();
        check("frame3_addr", 32'(rom_address), 24000);
      end
    end
    check("hold_busy", 32'(anim_busy), 0);
    pulse();
    check("hold_disp", 32'(disp_frame), 5);

    // Looping animation, then async reset mid-cycle
    anim_loop = 1; anim_start = 1;
    apply();
    for (int k = 1; k <= 37; k++) pulse();
    check("loop_disp", 32'(disp_frame), 0);
    check("loop_busy", 32'(anim_busy), 1);
    draw_x = 210; draw_y = 310;
    apply();
    #1 reset = 1'b1;
    #1;
    check("rst_addr", 32'(rom_address), 0);
    check("rst_hit", 32'(sprite_hit), 0);
    check("rst_hit_q", 32'(hit_q), 0);
    check("rst_disp", 32'(disp_frame), 0);
    check("rst_busy", 32'(anim_busy), 0);
    apply();
    reset = 1'b0;

    // Stop returns to idle with frame 0
    anim_start = 1;
    apply();
    for (int k = 0; k < 7; k++) pulse();
    anim_stop = 1;
    apply();
    check("stop_busy", 32'(anim_busy), 0);
    pulse();
    check("stop_disp", 32'(disp_frame), 0);

    // Start coinciding with a tick drops that tick
    anim_loop = 0; anim_start = 1;
    apply();
    for (int k = 0; k < 3; k++) pulse();
    anim_start = 1; frame_start = 1;
    apply();
    for (int k = 1; k <= 7; k++) begin
      pulse();
      if (k == 6) check("drop_disp6", 32'(disp_frame), 0);
      if (k == 7) check("drop_disp7", 32'(disp_frame), 1);
    end
    anim_start = 1; anim_stop = 1;
    apply();
    check("start_beats_stop", 32'(anim_busy), 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        spr_x = 10'($urandom); spr_y = 10'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        draw_x = 10'($urandom); draw_y = 10'($urandom);
      end else begin
        draw_x = 10'(int'(spr_x) + int'($urandom_range(0, 100)) - 10);
        draw_y = 10'(int'(spr_y) + int'($urandom_range(0, 120)) - 10);
      end
      flip_h      = 1'($urandom);
      frame_start = ($urandom_range(0, 3) == 0);
      anim_start  = ($urandom_range(0, 299) == 0);
      anim_stop   = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 199) == 0) anim_loop = ~anim_loop;
      reset = ($urandom_range(0, 699) == 0);
      apply();
    end
    reset = 1'b0;
    apply();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
